capture_sequencer: RTL
======================

Name: capture_sequencer

Overview:
Controls the BRAM capture address counter in the scale/acquisition path. Its outputs drive the counter's clock-enable and trigger inputs.
- Arms on software command and waits for an external or software trigger.
- Paces the capture with a decimating clock enable.
- Repeats for N shots with a holdoff between shots.
- After an abort, flushes the downstream counter back to address 0 so the next capture is aligned.

Parameters:
COUNT_WIDTH, 13, width of sample index; must equal downstream counter width
DECIM_WIDTH, 16, width of decimation ratio
SHOT_WIDTH, 16, width of shot count
HOLDOFF_WIDTH, 32, width of inter-shot holdoff counter

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
arm  in  1  start-sequence request, level sampled each cycle
abort  in  1  stop request, priority over arm
trig_in  in  1  external trigger, rising-edge sensitive
sw_trig  in  1  software trigger, single-cycle pulse
decim  in  DECIM_WIDTH  clken period minus 1
count_max  in  COUNT_WIDTH  last sample index of a shot
n_shots  in  SHOT_WIDTH  shots per sequence; 0 treated as 1
holdoff  in  HOLDOFF_WIDTH  idle cycles between shots
clken  out  1  clock enable to address counter
trig_out  out  1  one-cycle trigger pulse to address counter
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse on normal sequence completion
shot_count  out  SHOT_WIDTH  completed shots in current/last sequence
state  out  3  current FSM state encoding

Behaviour:
- Reset: state=IDLE, clken=0, trig_out=0, done=0, busy=0, shot_count=0, sample index=0, prescaler=0, trig_in edge register=0.
- FSM states: IDLE=0, WAIT_TRIG=1, START=2, CAPTURE=3, HOLDOFF=4, FLUSH=5.
- Configuration latching: decim, count_max, n_shots and holdoff are latched on the arm cycle and held constant until IDLE.
- IDLE -> WAIT_TRIG:
  - when arm=1 and abort=0.
  - latches config; clears shot_count.
  - arm is ignored in all other states.
- Trigger detection in WAIT_TRIG:
  - a trigger is (trig_in & ~trig_in_d) | sw_trig.
  - on a trigger, go to START.
  - triggers in all other states are discarded, not queued.
- START (exactly 1 cycle):
  - trig_out=1, clken=0.
  - prescaler cleared.
  - next state is CAPTURE.
- CAPTURE:
  - prescaler counts 0..decim; clken=1 for one cycle when prescaler==decim, then prescaler returns to 0.
  - decim=0 gives clken every cycle.
  - first clken occurs decim+1 cycles after the START cycle, so it is never coincident with trig_out.
  - sample index increments on each clken.
  - on the clken where index==count_max: index->0 and shot_count+1. If the new shot_count==max(n_shots,1), the next state is IDLE with done=1 for 1 cycle. Otherwise the next state is HOLDOFF if holdoff!=0, else WAIT_TRIG.
- Samples per shot: count_max+1 clken pulses; count_max=0 gives 1 sample.
- HOLDOFF:
  - down-counter loaded with holdoff; decrements each cycle; clken=0.
  - at 1 -> WAIT_TRIG; total HOLDOFF duration = holdoff cycles.
- clken outside CAPTURE/FLUSH: always 0.
- Abort:
  - from WAIT_TRIG, START or HOLDOFF: if index==0, go to IDLE next cycle; otherwise go to FLUSH.
  - from CAPTURE: go to FLUSH.
  - in all cases: no done pulse; shot_count is frozen.
- FLUSH:
  - clken=1 every cycle, ignoring decim, until index wraps through count_max to 0, then IDLE.
  - this keeps the downstream counter aligned at address 0.
  - abort is ignored during FLUSH.
- Simultaneous events:
  - abort and trigger in WAIT_TRIG: abort wins.
  - arm and abort in IDLE: stay IDLE.
- Reset mid-operation: returns to IDLE with reset values. The downstream counter is not flushed; software must pulse reset of both.
- Counter widths: all counters wrap modulo their width; index never exceeds count_max.

Optional Feature:
Macro: CAPTURE_SEQUENCER_TIMESTAMP_EN
- Defined:
  - adds a 64-bit free-running cycle counter, cleared by rst.
  - adds output trig_timestamp[63:0] and output ts_valid.
  - trig_timestamp latches the counter value on the START cycle.
  - ts_valid pulses for 1 cycle one cycle after START.
  - trig_timestamp holds its value until the next START.
- Undefined: neither port exists; no counter logic is present.

Test Plan:
1. rst; arm with decim=0, count_max=7, n_shots=1; one sw_trig pulse -> trig_out 1 cycle; 8 consecutive clken starting 1 cycle after trig_out; done pulse; shot_count=1; busy low afterwards.
2. decim=3, count_max=3 -> clken every 4th cycle, exactly 4 pulses per shot, first pulse 4 cycles after the trig_out cycle.
3. n_shots=3, holdoff=10; trig_in held high continuously, plus rising edges during HOLDOFF -> only edges arriving in WAIT_TRIG start shots; 10 idle cycles between shots; done after shot 3; shot_count=3.
4. Abort after 5 of 16 samples (count_max=15) -> FLUSH gives 11 back-to-back clken; IDLE; no done pulse; next sequence starts at index 0.
5. arm and abort asserted in the same IDLE cycle -> stays IDLE. sw_trig in IDLE -> no trig_out. n_shots=0 -> behaves as 1 shot.
6. With CAPTURE_SEQUENCER_TIMESTAMP_EN defined: trigger at cycle 100 after rst -> START at cycle 101, trig_timestamp=101, ts_valid pulse at cycle 102.

Source files
------------

// File: rtl/capture_sequencer_if.sv
// Control, configuration and status bundle for capture_sequencer.
// Timestamp signals are present only when CAPTURE_SEQUENCER_TIMESTAMP_EN is defined.
interface capture_sequencer_if #(
  parameter int COUNT_WIDTH   = 13,
  parameter int DECIM_WIDTH   = 16,
  parameter int SHOT_WIDTH    = 16,
  parameter int HOLDOFF_WIDTH = 32
);
  logic                     arm;
  logic                     abort;
  logic                     trig_in;
  logic                     sw_trig;
  logic [DECIM_WIDTH-1:0]   decim;
  logic [COUNT_WIDTH-1:0]   count_max;
  logic [SHOT_WIDTH-1:0]    n_shots;
  logic [HOLDOFF_WIDTH-1:0] holdoff;

  logic                     clken;
  logic                     trig_out;
  logic                     busy;
  logic                     done;
  logic [SHOT_WIDTH-1:0]    shot_count;
  logic [2:0]               state;
`ifdef CAPTURE_SEQUENCER_TIMESTAMP_EN
  logic [63:0]              trig_timestamp;
  logic                     ts_valid;
`endif

  modport master (
    output arm, abort, trig_in, sw_trig, decim, count_max, n_shots, holdoff,
    input  clken, trig_out, busy, done, shot_count, state
`ifdef CAPTURE_SEQUENCER_TIMESTAMP_EN
    , input trig_timestamp, ts_valid
`endif
  );

  modport slave (
    input  arm, abort, trig_in, sw_trig, decim, count_max, n_shots, holdoff,
    output clken, trig_out, busy, done, shot_count, state
`ifdef CAPTURE_SEQUENCER_TIMESTAMP_EN
    , output trig_timestamp, ts_valid
`endif
  );
endinterface

// File: rtl/capture_sequencer.sv
// Arms, triggers and paces the BRAM capture address counter; flushes it to 0 after abort.
// Optional trigger timestamping is enabled by defining CAPTURE_SEQUENCER_TIMESTAMP_EN.
module capture_sequencer #(
  parameter int COUNT_WIDTH   = 13,
  parameter int DECIM_WIDTH   = 16,
  parameter int SHOT_WIDTH    = 16,
  parameter int HOLDOFF_WIDTH = 32
) (
  input logic                clk,
  input logic                rst,
  capture_sequencer_if.slave bus
);
  // state     | meaning
  // IDLE      | not armed, config may change
  // WAIT_TRIG | armed, waiting for trig_in rising edge or sw_trig
  // START     | one-cycle trig_out to the address counter
  // CAPTURE   | decimated clken, one per sample
  // HOLDOFF   | idle gap between shots
  // FLUSH     | clken every cycle until the address counter wraps to 0
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_TRIG = 3'd1,
    START     = 3'd2,
    CAPTURE   = 3'd3,
    HOLDOFF   = 3'd4,
    FLUSH     = 3'd5
  } state_e;

  state_e                   state_q, state_d, abort_dest;
  logic [DECIM_WIDTH-1:0]   decim_q, decim_d, prescale_q, prescale_d;
  logic [COUNT_WIDTH-1:0]   count_max_q, count_max_d, index_q, index_d;
  logic [SHOT_WIDTH-1:0]    n_shots_q, n_shots_d, shot_count_q, shot_count_d;
  logic [SHOT_WIDTH-1:0]    shot_next, shot_target;
  logic [HOLDOFF_WIDTH-1:0] holdoff_q, holdoff_d, hold_cnt_q, hold_cnt_d;
  logic                     trig_d_q;
  logic                     clken_q, clken_d, trig_out_q, trig_out_d;
  logic                     done_q, done_d, busy_q, busy_d;
  logic                     trig_evt, sample_last;

  always_comb begin
    state_d      = state_q;
    decim_d      = decim_q;
    count_max_d  = count_max_q;
    n_shots_d    = n_shots_q;
    holdoff_d    = holdoff_q;
    prescale_d   = prescale_q;
    index_d      = index_q;
    shot_count_d = shot_count_q;
    hold_cnt_d   = hold_cnt_q;
    done_d       = 1'b0;

    trig_evt    = (bus.trig_in & ~trig_d_q) | bus.sw_trig;
    sample_last = clken_q && (index_q == count_max_q);
    shot_next   = shot_count_q + SHOT_WIDTH'(1);
    shot_target = (n_shots_q == '0) ? SHOT_WIDTH'(1) : n_shots_q;
    abort_dest  = (index_q == '0) ? IDLE : FLUSH;

    // index mirrors the downstream address counter: it moves on every clken issued
    if (clken_q) index_d = sample_last ? '0 : index_q + COUNT_WIDTH'(1);

    case (state_q)
      IDLE: begin
        if (bus.arm && !bus.abort) begin
          state_d      = WAIT_TRIG;
          decim_d      = bus.decim;
          count_max_d  = bus.count_max;
          n_shots_d    = bus.n_shots;
          holdoff_d    = bus.holdoff;
          shot_count_d = '0;
        end
      end
      WAIT_TRIG: begin
        if (bus.abort)   state_d = abort_dest;
        else if (trig_evt) state_d = START;
      end
      START: begin
        prescale_d = '0;
        state_d    = bus.abort ? abort_dest : CAPTURE;
      end
      CAPTURE: begin
        prescale_d = (prescale_q == decim_q) ? '0 : prescale_q + DECIM_WIDTH'(1);
        if (bus.abort) begin
          state_d = FLUSH;
        end else if (sample_last) begin
          shot_count_d = shot_next;
          if (shot_next == shot_target) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else if (holdoff_q != '0) begin
            state_d    = HOLDOFF;
            hold_cnt_d = holdoff_q;
          end else begin
            state_d = WAIT_TRIG;
          end
        end
      end
      HOLDOFF: begin
        if (bus.abort)                          state_d = abort_dest;
        else if (hold_cnt_q == HOLDOFF_WIDTH'(1)) state_d = WAIT_TRIG;
        else                                    hold_cnt_d = hold_cnt_q - HOLDOFF_WIDTH'(1);
      end
      FLUSH: begin
        if (sample_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // outputs are registered, so they are decoded from the next state
    trig_out_d = (state_d == START);
    clken_d    = (state_d == FLUSH) || ((state_d == CAPTURE) && (prescale_d == decim_q));
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      decim_q      <= '0;
      count_max_q  <= '0;
      n_shots_q    <= '0;
      holdoff_q    <= '0;
      prescale_q   <= '0;
      index_q      <= '0;
      shot_count_q <= '0;
      hold_cnt_q   <= '0;
      trig_d_q     <= 1'b0;
      clken_q      <= 1'b0;
      trig_out_q   <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      decim_q      <= decim_d;
      count_max_q  <= count_max_d;
      n_shots_q    <= n_shots_d;
      holdoff_q    <= holdoff_d;
      prescale_q   <= prescale_d;
      index_q      <= index_d;
      shot_count_q <= shot_count_d;
      hold_cnt_q   <= hold_cnt_d;
      trig_d_q     <= bus.trig_in;
      clken_q      <= clken_d;
      trig_out_q   <= trig_out_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.clken      = clken_q;
  assign bus.trig_out   = trig_out_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.shot_count = shot_count_q;
  assign bus.state      = state_q;

`ifdef CAPTURE_SEQUENCER_TIMESTAMP_EN
  logic [63:0] ts_cnt_q, trig_ts_q;
  logic        ts_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ts_cnt_q   <= '0;
      trig_ts_q  <= '0;
      ts_valid_q <= 1'b0;
    end else begin
      ts_cnt_q   <= ts_cnt_q + 64'd1;
      ts_valid_q <= (state_q == START);
      if (state_q == START) trig_ts_q <= ts_cnt_q;
    end
  end

  assign bus.trig_timestamp = trig_ts_q;
  assign bus.ts_valid       = ts_valid_q;
`endif
endmodule
